mul_acc: RTL and testbench
==========================

Name: mul_acc

Overview:
- Iterative multiply/accumulate unit in the execute stage, owning the HI/LO accumulator pair.
- Driven by execute-stage control: ACCEn, MULSelB and Func. Output is consumed on the OutSel=10 result path.
- Multi-cycle operations (MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL) assert Busy so the pipeline stalls.
- HI/LO moves (MTHI/MTLO/MFHI/MFLO) complete in a single cycle.

Parameters:
- BPC, 8, multiplier bits consumed per iteration. Legal values are 1, 2, 4, 8, 16.
- ITER, 32/BPC (derived, not overridable), iteration cycle count.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- En  input  1  operation valid this cycle (ACCEn, or OutSel==10)
- ALUOp  input  1  Func is decoded from the SPECIAL table
- MULOp  input  1  Func is decoded from the SPECIAL2 table
- Func  input  6  function code
- MULSelB  input  1  0 = MTHI/MTLO operand path
- Flush  input  1  abort in-flight operation
- A  input  32  rs operand
- B  input  32  rt operand
- Result  output  32  MUL product low word, or HI/LO for MFHI/MFLO
- Busy  output  1  stall request
- Done  output  1  one-cycle pulse on multi-cycle completion

Behaviour:
- Decode with ALUOp=1:
  - 18 = MULT, 19 = MULTU
  - 10 = MFHI, 11 = MTHI, 12 = MFLO, 13 = MTLO
- Decode with MULOp=1:
  - 00 = MADD, 01 = MADDU, 02 = MUL, 04 = MSUB, 05 = MSUBU
- Any other code, or En=0: no operation.
- Reset (async, any state): HI=0, LO=0, state=IDLE, Busy=0, Done=0, Result=0, internal registers cleared.
- States: IDLE, CALC, FIN.
- IDLE:
  - En with a multi-cycle op: latch |A|, |B|, negate flag and op; clear partial product; iteration count=0; go to CALC.
    - Signed ops (MULT/MADD/MSUB/MUL): negate flag = A[31]^B[31].
    - Unsigned ops: operands are taken raw and negate flag = 0.
  - MTHI/MTLO (MULSelB=0): HI (or LO) <= A at this edge. No state change.
  - MFHI/MFLO: Result = HI (or LO), combinational, same cycle.
- CALC:
  - Each cycle: partial += |A| * |B|[k*BPC +: BPC] << (k*BPC); k++.
  - After ITER cycles, go to FIN.
- FIN:
  - Apply sign: P = negate ? -partial : partial, 64-bit two's complement.
  - At the FIN edge:
    - MULT/MULTU: {HI,LO} <= P.
    - MADD/MADDU: {HI,LO} <= {HI,LO} + P, mod 2^64.
    - MSUB/MSUBU: {HI,LO} <= {HI,LO} - P, mod 2^64.
    - MUL: HI/LO unchanged.
  - Done=1 during FIN. For MUL, Result=P[31:0] during FIN; otherwise Result=0.
  - Return to IDLE.
- Busy is registered: high in every CALC and FIN cycle. With default BPC=8, Busy is high for ITER+1=5 cycles, starting the cycle after acceptance.
- En while Busy: ignored entirely, including MF/MT ops. The upstream interlock must hold the instruction.
- MFHI/MFLO issued the cycle after Done: returns the updated value, with no forwarding gap.
- Flush in CALC or FIN: go to IDLE next edge. HI/LO are unchanged and Done is suppressed. Flush in IDLE has no effect.
- Flush and En in the same IDLE cycle: Flush wins and nothing is accepted.
- Result outside MFHI/MFLO/FIN-MUL: 0.
- Reset mid-operation: immediate return to IDLE with HI/LO=0. No Done pulse.

Test Plan:
- MULT A=FFFFFFFD (-3), B=00000007 -> Busy high 5 cycles. Done pulse in cycle 5. Then MFHI=FFFFFFFF, MFLO=FFFFFFEB.
- MULTU A=B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Repeat with BPC=1 -> Busy high 33 cycles, same result.
- MTHI A=00000000 and MTLO A=FFFFFFFF, then MADDU A=1, B=1 -> HI=00000001, LO=00000000 (carry across LO). Then MSUB A=1, B=1 -> HI=00000000, LO=FFFFFFFF.
- MUL A=00010000, B=00010000 with HI=12345678 beforehand -> Result=00000000 in FIN with Done=1. HI still 12345678. Then MUL A=-2, B=3 -> Result=FFFFFFFA.
- MULT issued, then En with MFLO during the Busy cycles -> MFLO ignored. MFLO re-issued after Done returns the new LO.
- Flush in the 2nd CALC cycle of MULT -> no Done pulse, HI/LO keep their prior values. Assert rst mid-CALC -> Busy=0 and HI=LO=0 immediately, asynchronously.

Source files
------------

// File: rtl/mul_acc.sv
// mul_acc: iterative multiply/accumulate unit owning the HI/LO accumulator pair
module mul_acc #(
  parameter int BPC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        ALUOp,
  input  logic        MULOp,
  input  logic [5:0]  Func,
  input  logic        MULSelB,
  input  logic        Flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        Busy,
  output logic        Done
);
  localparam int ITER = 32 / BPC;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  typedef enum logic [1:0] {K_MULT, K_MADD, K_MSUB, K_MUL} kind_t;
  state_t state, state_n;
  kind_t kind, kind_d;
  logic [31:0] hi, lo, b_sh, a_abs, b_abs;
  logic [63:0] a_sh, partial, prod, p, acc_n;
  logic [5:0] k;
  logic neg, busy_q, take, multi, sgn;
  logic is_mult, is_multu, is_madd, is_maddu, is_mul, is_msub, is_msubu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  assign is_mult  = ALUOp & (Func == 6'h18);
  assign is_multu = ALUOp & (Func == 6'h19);
  assign is_mfhi  = ALUOp & (Func == 6'h10);
  assign is_mthi  = ALUOp & (Func == 6'h11);
  assign is_mflo  = ALUOp & (Func == 6'h12);
  assign is_mtlo  = ALUOp & (Func == 6'h13);
  assign is_madd  = MULOp & (Func == 6'h00);
  assign is_maddu = MULOp & (Func == 6'h01);
  assign is_mul   = MULOp & (Func == 6'h02);
  assign is_msub  = MULOp & (Func == 6'h04);
  assign is_msubu = MULOp & (Func == 6'h05);
  assign multi = is_mult | is_multu | is_madd | is_maddu | is_mul | is_msub | is_msubu;
  assign sgn = is_mult | is_madd | is_msub | is_mul;
  assign kind_d = (is_madd | is_maddu) ? K_MADD : (is_msub | is_msubu) ? K_MSUB : is_mul ? K_MUL : K_MULT;
  assign take = (state == IDLE) & En & ~Flush;
  assign a_abs = (sgn & A[31]) ? -A : A;
  assign b_abs = (sgn & B[31]) ? -B : B;
  assign prod = a_sh * {{(64 - BPC){1'b0}}, b_sh[BPC-1:0]};
  assign p = neg ? -partial : partial;
  assign acc_n = kind == K_MADD ? {hi, lo} + p : kind == K_MSUB ? {hi, lo} - p : p;
  assign Done = (state == FIN) & ~Flush;
  assign Busy = busy_q;
  assign Result = (Done & (kind == K_MUL)) ? p[31:0] : (take & is_mfhi) ? hi : (take & is_mflo) ? lo : 32'd0;
  // next state: flush aborts, CALC runs ITER cycles, FIN lasts one cycle
  always_comb begin
    state_n = Flush ? IDLE : (take & multi) ? CALC : (state == CALC && k == 6'(ITER - 1)) ? FIN : (state == FIN) ? IDLE : state;
  end
  // state and registered busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= state_n != IDLE;
    end
  end
  // operand latch, shift-and-add iteration, HI/LO writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      k       <= '0;
      neg     <= 1'b0;
      kind    <= K_MULT;
    end else if (state == IDLE) begin
      if (take & multi) begin
        a_sh    <= {32'd0, a_abs};
        b_sh    <= b_abs;
        neg     <= sgn & (A[31] ^ B[31]);
        kind    <= kind_d;
        partial <= '0;
        k       <= '0;
      end
      if (take & ~MULSelB & is_mthi) hi <= A;
      if (take & ~MULSelB & is_mtlo) lo <= A;
    end else if (state == CALC) begin
      partial <= partial + prod;
      a_sh    <= a_sh << BPC;
      b_sh    <= b_sh >> BPC;
      k       <= k + 6'd1;
    end else if (~Flush & (kind != K_MUL)) begin
      {hi, lo} <= acc_n;
    end
  end
endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: scoreboard bench for mul_acc at BPC=8 and BPC=1
module tb_mul_acc;
  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  logic clk = 0, rst = 1, en8 = 0, en1 = 0, alu = 0, mulop = 0, msb = 1, flush = 0;
  logic [5:0] func = 0;
  logic [31:0] a = 0, b = 0, r8, r1;
  logic busy8, done8, busy1, done1;
  int checks = 0, errors = 0;
  exp_t q8[$], q1[$];
  exp_t e8, e1;
  mul_acc #(.BPC(8)) u8 (.clk(clk), .rst(rst), .En(en8), .ALUOp(alu), .MULOp(mulop), .Func(func),
    .MULSelB(msb), .Flush(flush), .A(a), .B(b), .Result(r8), .Busy(busy8), .Done(done8));
  mul_acc #(.BPC(1)) u1 (.clk(clk), .rst(rst), .En(en1), .ALUOp(alu), .MULOp(mulop), .Func(func),
    .MULSelB(msb), .Flush(flush), .A(a), .B(b), .Result(r1), .Busy(busy1), .Done(done1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input bit u, input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v = v;
    if (u) q1.push_back(e);
    else q8.push_back(e);
  endtask
  task automatic op(input bit u, input bit al, input bit ml, input logic [5:0] f,
                    input logic [31:0] a_, input logic [31:0] b_, input bit sel = 1'b1);
    alu = al; mulop = ml; func = f; a = a_; b = b_; msb = sel;
    if (u) en1 = 1; else en8 = 1;
    @(posedge clk); #1;
    en1 = 0; en8 = 0; alu = 0; mulop = 0; msb = 1;
  endtask
  task automatic wait_busy(input bit u, input int exp);
    int n = 0;
    while ((u ? busy1 : busy8) && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk(u ? "busy_len1" : "busy_len8", 32'(n), 32'(exp));
  endtask
  task automatic mf(input bit u, input bit h, input logic [31:0] v);
    push(u, h ? "mfhi" : "mflo", v);
    op(u, 1, 0, h ? 6'h10 : 6'h12, 0, 0);
  endtask
  task automatic mc(input bit u, input bit al, input logic [5:0] f, input logic [31:0] a_,
                    input logic [31:0] b_, input logic [31:0] res, input int nb);
    push(u, "fin_result", res);
    op(u, al, ~al, f, a_, b_);
    wait_busy(u, nb);
  endtask
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done8: Result=%h with nothing expected", r8);
      end else begin
        e8 = q8.pop_front();
        chk(e8.nm, r8, e8.v);
      end
    end
    if (!rst && en8 && alu && (func == 6'h10 || func == 6'h12) && !flush) begin
      if (busy8) chk("mf_while_busy", r8, 32'h0);
      else if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mf8: Result=%h with nothing expected", r8);
      end else begin
        e8 = q8.pop_front();
        chk(e8.nm, r8, e8.v);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1: Result=%h with nothing expected", r1);
      end else begin
        e1 = q1.pop_front();
        chk({"bpc1_", e1.nm}, r1, e1.v);
      end
    end
    if (!rst && en1 && alu && (func == 6'h10 || func == 6'h12) && !flush && !busy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mf1: Result=%h with nothing expected", r1);
      end else begin
        e1 = q1.pop_front();
        chk({"bpc1_", e1.nm}, r1, e1.v);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", r8, 0);
    rst = 0;
    @(posedge clk); #1;
    mc(0, 1, 6'h18, 32'hFFFFFFFD, 32'h7, 32'h0, 5);
    mf(0, 1, 32'hFFFFFFFF);
    mf(0, 0, 32'hFFFFFFEB);
    mc(0, 1, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5);
    mf(0, 1, 32'hFFFFFFFE);
    mf(0, 0, 32'h00000001);
    op(0, 1, 0, 6'h11, 32'h0, 0, 0);
    op(0, 1, 0, 6'h13, 32'hFFFFFFFF, 0, 0);
    mc(0, 0, 6'h01, 32'h1, 32'h1, 32'h0, 5);
    mf(0, 1, 32'h00000001);
    mf(0, 0, 32'h00000000);
    mc(0, 0, 6'h04, 32'h1, 32'h1, 32'h0, 5);
    mf(0, 1, 32'h00000000);
    mf(0, 0, 32'hFFFFFFFF);
    op(0, 1, 0, 6'h11, 32'h12345678, 0, 0);
    mc(0, 0, 6'h02, 32'h00010000, 32'h00010000, 32'h0, 5);
    mf(0, 1, 32'h12345678);
    mc(0, 0, 6'h02, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 5);
    mf(0, 1, 32'h12345678);
    mf(0, 0, 32'hFFFFFFFF);
    push(0, "fin_result", 32'h0);
    op(0, 1, 0, 6'h18, 32'h5, 32'h6);
    op(0, 1, 0, 6'h12, 0, 0);
    op(0, 1, 0, 6'h13, 32'hDEADBEEF, 0, 0);
    wait_busy(0, 3);
    mf(0, 0, 32'h0000001E);
    mf(0, 1, 32'h00000000);
    op(0, 1, 0, 6'h18, 32'h9, 32'h9);
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", busy8, 0);
    repeat (6) @(posedge clk);
    #1;
    mf(0, 1, 32'h00000000);
    mf(0, 0, 32'h0000001E);
    flush = 1;
    op(0, 1, 0, 6'h18, 32'h9, 32'h9);
    chk("flush_idle_busy", busy8, 0);
    op(0, 1, 0, 6'h11, 32'hFFFF, 0, 0);
    flush = 0;
    repeat (6) @(posedge clk);
    #1;
    mf(0, 1, 32'h00000000);
    op(0, 1, 0, 6'h11, 32'h77, 0, 0);
    op(0, 1, 0, 6'h18, 32'h2, 32'h3);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rst_mid_busy", busy8, 0);
    chk("rst_mid_done", done8, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    mf(0, 1, 32'h00000000);
    mf(0, 0, 32'h00000000);
    mc(1, 1, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33);
    mf(1, 1, 32'hFFFFFFFE);
    mf(1, 0, 32'h00000001);
    repeat (3) @(posedge clk);
    #1;
    chk("q8_left", 32'(q8.size()), 0);
    chk("q1_left", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
